// File: rtl/beatmap_pkg.sv
// Shared types and helpers for the beatmap note scheduler: FSM states, lane width
// and the upstream word legality check.
package beatmap_pkg;

    localparam int LANE_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BEAT = 2'd1,
        PRESENT   = 2'd2
    } state_t;

    // A word is legal when only the lane field is populated and the lane exists.
    function automatic logic word_is_legal(input logic [7:0] word, input int lanes);
        return (word[7:5] == 3'b000) && (word[1:0] == 2'b00) &&
               (int'({29'd0, word[4:2]}) < lanes);
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Lane-code FIFO: DEPTH entries of LANE_W bits, with a registered occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module note_fifo
    import beatmap_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [LANE_W-1:0]        wdata,
    input  logic                     pop,
    output logic [LANE_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic [LANE_W-1:0] mem [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read between valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/beatmap_note_scheduler.sv
// Beatmap note scheduler: decodes upstream lane words into a FIFO and releases
// one note per beat_tick to a valid/ready consumer while playback runs.
module beatmap_note_scheduler
    import beatmap_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LANES = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   data_en,
    input  logic [7:0]             data,
    input  logic                   beat_tick,
    input  logic                   game_run,
    input  logic                   note_ready,
    output logic                   note_valid,
    output logic [LANE_W-1:0]      note_lane,
    output logic [7:0]             note_beat,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   full,
    output logic                   empty,
    output logic [7:0]             drop_cnt,
    output state_t                 dbg_state,
    output logic [7:0]             dbg_beat_cnt
);

    state_t            state;
    state_t            next_state;
    logic [7:0]        beat_cnt;
    logic              word_legal;
    logic              push_ok;
    logic              pop;
    logic [LANE_W-1:0] head_lane;

    assign word_legal = word_is_legal(data, LANES);
    assign push_ok    = data_en && word_legal && (!full || pop);

    note_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_ok),
        .wdata  (data[4:2]),
        .pop    (pop),
        .rdata  (head_lane),
        .count  (fifo_count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt <= '0;
        end else if (data_en && !push_ok && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt <= '0;
        end else if (game_run && beat_tick) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Output handshake: note_valid is high exactly in PRESENT; a note is consumed in
    // the cycle where note_valid && note_ready, and lane/beat hold until then.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (game_run) next_state = WAIT_BEAT;
            end
            WAIT_BEAT: begin
                if (!game_run) begin
                    next_state = IDLE;
                end else if (beat_tick && !empty) begin
                    pop        = 1'b1;
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (!game_run) begin
                    next_state = IDLE;
                end else if (note_ready) begin
                    next_state = WAIT_BEAT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // note_beat captures the beat index before this tick's increment.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            note_lane <= '0;
            note_beat <= '0;
        end else if (pop) begin
            note_lane <= head_lane;
            note_beat <= beat_cnt;
        end
    end

    assign note_valid   = (state == PRESENT);
    assign dbg_state    = state;
    assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_beatmap_note_scheduler.sv
// Self-checking bench for beatmap_note_scheduler: decode table, note scoreboard and
// hand-written multi-cycle sequences (full FIFO, stall, wrap, stop, async reset).
module tb_beatmap_note_scheduler;
    import beatmap_pkg::*;

    logic       clk;
    logic       resetn;
    logic       data_en;
    logic [7:0] data;
    logic       beat_tick;
    logic       game_run;
    logic       note_ready;
    logic       note_valid;
    logic [2:0] note_lane;
    logic [7:0] note_beat;
    logic [3:0] fifo_count;
    logic       full;
    logic       empty;
    logic [7:0] drop_cnt;
    state_t     dbg_state;
    logic [7:0] dbg_beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_q[$];
    logic [7:0] bench_beat;

    typedef struct {
        logic       en;
        logic [7:0] word;
        logic       push;
        logic       drop;
    } vec_t;

    vec_t vecs[11];

    beatmap_note_scheduler dut (
        .clk          (clk),
        .resetn       (resetn),
        .data_en      (data_en),
        .data         (data),
        .beat_tick    (beat_tick),
        .game_run     (game_run),
        .note_ready   (note_ready),
        .note_valid   (note_valid),
        .note_lane    (note_lane),
        .note_beat    (note_beat),
        .fifo_count   (fifo_count),
        .full         (full),
        .empty        (empty),
        .drop_cnt     (drop_cnt),
        .dbg_state    (dbg_state),
        .dbg_beat_cnt (dbg_beat_cnt)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        data_en    = 1'b0;
        data       = 8'd0;
        beat_tick  = 1'b0;
        game_run   = 1'b0;
        note_ready = 1'b0;
        repeat (2) cycle();
        resetn     = 1'b1;
        exp_q.delete();
        bench_beat = 8'd0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic push_word(input logic [7:0] w, input logic accept);
        data_en = 1'b1;
        data    = w;
        cycle();
        data_en = 1'b0;
        data    = 8'd0;
        if (accept) exp_q.push_back(w[4:2]);
    endtask

    task automatic tick();
        beat_tick = 1'b1;
        cycle();
        beat_tick = 1'b0;
        if (game_run) bench_beat = bench_beat + 8'd1;
    endtask

    // Scoreboard: compare the presented note with the oldest expected lane, then accept it.
    task automatic accept_note(input string name, input logic [7:0] exp_beat);
        logic [2:0] exp_lane;
        check({name, " valid"}, note_valid, 1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got note lane %0d, expected no note", name, note_lane);
        end else begin
            exp_lane = exp_q.pop_front();
            check({name, " lane"}, note_lane, exp_lane);
        end
        check({name, " beat"}, note_beat, exp_beat);
        note_ready = 1'b1;
        cycle();
        note_ready = 1'b0;
        check({name, " valid drop"}, note_valid, 0);
    endtask

    task automatic present_next(input string name);
        logic [7:0] b;
        b = bench_beat;
        tick();
        accept_note(name, b);
    endtask

    initial begin
        vecs[0]  = '{en: 1'b1, word: 8'd20,  push: 1'b0, drop: 1'b1};
        vecs[1]  = '{en: 1'b1, word: 8'd2,   push: 1'b0, drop: 1'b1};
        vecs[2]  = '{en: 1'b1, word: 8'd32,  push: 1'b0, drop: 1'b1};
        vecs[3]  = '{en: 1'b1, word: 8'd28,  push: 1'b0, drop: 1'b1};
        vecs[4]  = '{en: 1'b1, word: 8'd24,  push: 1'b0, drop: 1'b1};
        vecs[5]  = '{en: 1'b1, word: 8'h81,  push: 1'b0, drop: 1'b1};
        vecs[6]  = '{en: 1'b0, word: 8'd20,  push: 1'b0, drop: 1'b0};
        vecs[7]  = '{en: 1'b1, word: 8'd4,   push: 1'b1, drop: 1'b0};
        vecs[8]  = '{en: 1'b1, word: 8'd16,  push: 1'b1, drop: 1'b0};
        vecs[9]  = '{en: 1'b1, word: 8'd0,   push: 1'b1, drop: 1'b0};
        vecs[10] = '{en: 1'b0, word: 8'd12,  push: 1'b0, drop: 1'b0};

        // Reset values
        do_reset();
        check("rst note_valid", note_valid, 0);
        check("rst fifo_count", fifo_count, 0);
        check("rst empty", empty, 1);
        check("rst full", full, 0);
        check("rst drop_cnt", drop_cnt, 0);
        check("rst state", dbg_state, IDLE);

        // Five lanes in order, one per beat
        game_run = 1'b1;
        cycle();
        check("run state", dbg_state, WAIT_BEAT);
        for (int i = 0; i < 5; i++) push_word(8'(i * 4), 1'b1);
        check("seq count", fifo_count, 5);
        for (int i = 0; i < 5; i++) begin
            check("seq idle valid", note_valid, 0);
            present_next("seq");
        end
        check("seq empty", empty, 1);

        // Decode table
        do_reset();
        game_run = 1'b1;
        cycle();
        begin
            int cnt_exp;
            int drop_exp;
            cnt_exp  = 0;
            drop_exp = 0;
            foreach (vecs[i]) begin
                data_en = vecs[i].en;
                data    = vecs[i].word;
                cycle();
                data_en = 1'b0;
                if (vecs[i].push) begin
                    exp_q.push_back(vecs[i].word[4:2]);
                    cnt_exp++;
                end
                if (vecs[i].drop) drop_exp++;
                check($sformatf("dec[%0d] count", i), fifo_count, cnt_exp);
                check($sformatf("dec[%0d] drop", i), drop_cnt, drop_exp);
                if (i == 2) check("dec three drops", drop_cnt, 3);
            end
        end
        for (int i = 0; i < 3; i++) present_next("dec drain");

        // Fill past full, then push while popping
        do_reset();
        game_run = 1'b1;
        cycle();
        for (int i = 0; i < 9; i++) push_word(8'((i % 5) * 4), i < 8);
        check("full flag", full, 1);
        check("full count", fifo_count, 8);
        check("full empty", empty, 0);
        check("full drop", drop_cnt, 1);
        begin
            logic [7:0] b;
            b         = bench_beat;
            data_en   = 1'b1;
            data      = 8'd12;
            beat_tick = 1'b1;
            cycle();
            data_en   = 1'b0;
            beat_tick = 1'b0;
            bench_beat = bench_beat + 8'd1;
            exp_q.push_back(3'd3);
            check("pushpop count", fifo_count, 8);
            check("pushpop full", full, 1);
            check("pushpop drop", drop_cnt, 1);
            accept_note("pushpop", b);
        end
        for (int i = 0; i < 8; i++) present_next("full drain");
        check("full drained", empty, 1);

        // Stall: consumer not ready across three beats
        do_reset();
        game_run = 1'b1;
        cycle();
        push_word(8'd8, 1'b1);
        push_word(8'd16, 1'b1);
        begin
            logic [7:0] b;
            b = bench_beat;
            tick();
            for (int i = 0; i < 3; i++) begin
                cycle();
                tick();
                check("stall valid", note_valid, 1);
                check("stall lane", note_lane, 2);
                check("stall beat", note_beat, b);
                check("stall count", fifo_count, 1);
            end
            check("stall beat_cnt", dbg_beat_cnt, bench_beat);
            check("stall beat_cnt abs", dbg_beat_cnt, 4);
            accept_note("stall", b);
        end
        present_next("stall next");

        // Beat counter wrap and stop during PRESENT
        do_reset();
        game_run = 1'b1;
        cycle();
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 254) check("beat 255", dbg_beat_cnt, 255);
            cycle();
        end
        check("beat wrap", dbg_beat_cnt, 0);
        check("rest no note", note_valid, 0);
        game_run = 1'b0;
        cycle();
        tick();
        check("beat hold", dbg_beat_cnt, 0);
        game_run = 1'b1;
        cycle();
        push_word(8'd4, 1'b1);
        push_word(8'd8, 1'b1);
        tick();
        check("stop pre valid", note_valid, 1);
        game_run = 1'b0;
        cycle();
        check("stop valid", note_valid, 0);
        check("stop state", dbg_state, IDLE);
        check("stop count", fifo_count, 1);
        void'(exp_q.pop_front());
        game_run = 1'b1;
        cycle();
        present_next("after stop");

        // Asynchronous reset mid-operation
        do_reset();
        game_run = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) push_word(8'(i * 4), 1'b1);
        tick();
        check("pre-rst valid", note_valid, 1);
        check("pre-rst count", fifo_count, 4);
        #2;
        resetn = 1'b0;
        #1;
        check("arst valid", note_valid, 0);
        check("arst lane", note_lane, 0);
        check("arst beat", note_beat, 0);
        check("arst count", fifo_count, 0);
        check("arst empty", empty, 1);
        check("arst full", full, 0);
        check("arst drop", drop_cnt, 0);
        check("arst state", dbg_state, IDLE);
        check("arst beat_cnt", dbg_beat_cnt, 0);
        cycle();
        resetn = 1'b1;
        exp_q.delete();
        bench_beat = 8'd0;
        cycle();
        push_word(8'd12, 1'b1);
        check("post-rst count", fifo_count, 1);
        present_next("post-rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/beatmap_note_scheduler.md
BEATMAP_NOTE_SCHEDULER -- requirements
Module: beatmap_note_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter LANES, default 5, number of valid lane codes (max 8).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port data_en, input, 1, upstream beatmap word valid, sampled every cycle.
REQ-006 SHALL have port data, input, 8, upstream beatmap word.
REQ-007 SHALL have port beat_tick, input, 1, one-cycle beat pulse.
REQ-008 SHALL have port game_run, input, 1, playback enable level.
REQ-009 SHALL have port note_ready, input, 1, downstream accepts the note.
REQ-010 SHALL have port note_valid, output, 1, a note is presented.
REQ-011 SHALL have port note_lane, output, 3, lane of the presented note.
REQ-012 SHALL have port note_beat, output, 8, beat index at which the note was released.
REQ-013 SHALL have port fifo_count, output, $clog2(DEPTH)+1, entries held.
REQ-014 SHALL have ports full and empty, output, 1 each, FIFO status.
REQ-015 SHALL have port drop_cnt, output, 8, count of discarded upstream words.

Function
REQ-016 SHALL decode each word: lane = data[4:2]; word legal iff data[7:5]==0, data[1:0]==0 and lane<LANES.
REQ-017 SHALL push lane into the FIFO when data_en=1, the word is legal and the FIFO is not full after this cycle's pop; fifo_count updates in the following cycle.
REQ-018 SHALL increment drop_cnt for each data_en=1 cycle whose word is illegal or cannot be pushed; drop_cnt saturates at 255.
REQ-019 SHALL accept a push into a full FIFO in the same cycle a pop occurs; count stays DEPTH.
REQ-020 SHALL keep beat_cnt (8 bit) incrementing on each beat_tick while game_run=1, wrapping 255->0, and holding when game_run=0.
REQ-021 SHALL implement FSM IDLE, WAIT_BEAT, PRESENT.
REQ-022 SHALL transition IDLE->WAIT_BEAT when game_run=1.
REQ-023 SHALL, in WAIT_BEAT, on beat_tick with FIFO non-empty, pop the head, register note_lane and note_beat (= beat_cnt before the increment), assert note_valid next cycle, and go to PRESENT.
REQ-024 SHALL treat a beat_tick in WAIT_BEAT with FIFO empty as a rest: no pop, no state change.
REQ-025 SHALL hold note_valid, note_lane and note_beat stable in PRESENT until note_ready=1, then deassert note_valid next cycle and return to WAIT_BEAT.
REQ-026 SHALL ignore beat_tick for popping while in PRESENT (beat_cnt still advances); no second note is queued.
REQ-027 SHALL return to IDLE from any state when game_run=0, dropping note_valid the next cycle without popping; FIFO contents are retained.
REQ-028 SHALL assert full iff fifo_count==DEPTH and empty iff fifo_count==0, both derived from registered state.

Reset
REQ-029 SHALL, on resetn=0, asynchronously clear the FSM to IDLE, pointers, fifo_count, beat_cnt, drop_cnt, note_lane and note_beat to 0, note_valid to 0, empty to 1 and full to 0.
REQ-030 SHALL discard any in-flight note and all FIFO contents when reset is asserted mid-operation; the first push after release is accepted normally.

Structure
REQ-031 SHALL place the FSM state enum, the LANE_W=3 constant and the legal-word check function in a shared package, beatmap_pkg.
REQ-032 SHALL implement storage as one sub-module, note_fifo (DEPTH x LANE_W, push/pop/count/full/empty).

Verification
REQ-033 SHALL cover: game_run=1, upstream words 0,4,8,12,16 then beat_tick x5 -> note_lane 0,1,2,3,4 with note_beat 0..4, each note_valid one cycle after its tick.
REQ-034 SHALL cover: data=8'd20, 8'd2 and 8'd32 with data_en=1 -> no push, drop_cnt=3.
REQ-035 SHALL cover: 9 legal pushes with no ticks (DEPTH=8) -> full=1, fifo_count=8, drop_cnt=1; a push coinciding with a pop while full -> accepted, count stays 8.
REQ-036 SHALL cover: note_ready held 0 for 3 beat_ticks -> note_valid/lane held, fifo_count unchanged, beat_cnt +3; note_ready=1 -> next cycle note_valid=0.
REQ-037 SHALL cover: 256 beat_ticks -> beat_cnt wraps to 0; game_run=0 in PRESENT -> IDLE, note_valid=0, FIFO count retained.
REQ-038 SHALL cover: resetn pulsed low with 4 entries and note_valid=1 -> all outputs at REQ-029 values immediately, without waiting for a clk edge.
